sample_ram_write_ctrl: RTL and testbench

//  Avalon-MM slave that lets the Nios II load the shared 16-bit sample RAM without per-word

---
 rtl/sample_ram_write_ctrl_pkg.sv | 30 +++
 rtl/sample_ram_write_ctrl_sync_fifo.sv | 62 ++++++
 rtl/sample_ram_write_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_sample_ram_write_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_ram_write_ctrl_pkg.sv
// Shared register map, control/status bit positions and FSM encoding for the
// sample RAM write controller.
package sample_ram_write_ctrl_pkg;

  localparam logic [1:0] REG_ADDR = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_FILL = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits
  localparam int CTRL_AUTOINC  = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_OVF  = 2;
  localparam int CTRL_CLR_DONE = 3;

  // CTRL read bits
  localparam int STAT_AUTOINC = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_DONE    = 2;
  localparam int STAT_BUSY    = 3;
  localparam int STAT_EMPTY   = 4;
  localparam int STAT_IRQ_EN  = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FILL  = 2'd2
  } state_e;

endpackage

// File: rtl/sample_ram_write_ctrl_sync_fifo.sv
// Single-clock show-ahead FIFO. Also exposes the entry behind the head so the
// owner can preload its output registers in the same cycle as a pop.
module sample_ram_write_ctrl_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head_next
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign head       = mem_q[rd_ptr_q];
  assign head_next  = mem_q[rd_ptr_nxt];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: storage has no reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sample_ram_write_ctrl.sv
// Avalon-MM slave that queues CPU writes (auto-incrementing address) and hardware
// FILL bursts onto the shared sample RAM write port under the arbiter's grant.
module sample_ram_write_ctrl
  import sample_ram_write_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic              ram_gnt,
  output logic              irq
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WORD_W = ADDR_W + DATA_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
  logic                autoinc_q, autoinc_d;
  logic                irq_en_q, irq_en_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [15:0]         rem_q, rem_d;
  logic [DATA_W-1:0]   fill_val_q, fill_val_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic                wr, wr_addr, wr_data, wr_fill, wr_ctrl;
  logic [15:0]         fill_len;
  logic                busy, push_ok, push_drop, pop, fill_start, fill_rej;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [WORD_W-1:0]   push_word, fifo_head, fifo_head_next, next_word;

  assign wr        = chipselect && !write_n;
  assign wr_addr   = wr && (address == REG_ADDR);
  assign wr_data   = wr && (address == REG_DATA);
  assign wr_fill   = wr && (address == REG_FILL);
  assign wr_ctrl   = wr && (address == REG_CTRL);
  assign fill_len  = writedata[31:16];
  assign push_word = {addr_ptr_q, writedata[DATA_W-1:0]};

  // Full is judged on the pre-pop count, so a push at full drops even when a pop coincides.
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign push_ok    = wr_data && !fifo_full && (state_q != S_FILL);
  assign push_drop  = wr_data && !push_ok;
  assign pop        = (state_q == S_DRAIN) && ram_gnt;
  assign fill_start = wr_fill && !busy && (fill_len != '0);
  assign fill_rej   = wr_fill && busy && (fill_len != '0);

  sample_ram_write_ctrl_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_ok),
    .push_data (push_word),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head),
    .head_next (fifo_head_next)
  );

  // Word the FIFO head will hold after this edge; lets ram_addr/ram_wdata be registered
  // without losing a cycle after a push or a pop.
  always_comb begin
    if (!fifo_empty && !pop)              next_word = fifo_head;
    else if (pop && fifo_count > CNT_W'(1)) next_word = fifo_head_next;
    else                                  next_word = push_word;
  end

  always_comb begin
    state_d     = state_q;
    addr_ptr_d  = addr_ptr_q;
    autoinc_d   = autoinc_q;
    irq_en_d    = irq_en_q;
    ovf_d       = ovf_q;
    done_d      = done_q;
    rem_d       = rem_q;
    fill_val_d  = fill_val_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    if (wr_addr) addr_ptr_d = writedata[ADDR_W-1:0];
    if (push_ok && autoinc_q) addr_ptr_d = addr_ptr_q + ADDR_W'(1);
    if (fill_start) addr_ptr_d = addr_ptr_q + ADDR_W'(fill_len);

    // Clears are applied before the sets below so that a coincident set wins.
    if (wr_ctrl) begin
      autoinc_d = writedata[CTRL_AUTOINC];
      irq_en_d  = writedata[CTRL_IRQ_EN];
      if (writedata[CTRL_CLR_OVF])  ovf_d  = 1'b0;
      if (writedata[CTRL_CLR_DONE]) done_d = 1'b0;
    end
    if (push_drop || fill_rej) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty || push_ok) begin
          state_d                   = S_DRAIN;
          ram_we_d                  = 1'b1;
          {ram_addr_d, ram_wdata_d} = next_word;
        end else if (fill_start) begin
          state_d     = S_FILL;
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_ptr_q;
          ram_wdata_d = writedata[DATA_W-1:0];
          fill_val_d  = writedata[DATA_W-1:0];
          rem_d       = fill_len;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_count == CNT_W'(1) && !push_ok) begin
          state_d  = S_IDLE;
          ram_we_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          {ram_addr_d, ram_wdata_d} = next_word;
        end
      end
      S_FILL: begin
        if (ram_gnt) begin
          if (rem_q == 16'd1) begin
            state_d  = S_IDLE;
            ram_we_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            ram_addr_d = ram_addr_q + ADDR_W'(1);
          end
          rem_d = rem_q - 16'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ram_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_ptr_q  <= '0;
      autoinc_q   <= 1'b1;
      irq_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      rem_q       <= '0;
      fill_val_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_ptr_q  <= addr_ptr_d;
      autoinc_q   <= autoinc_d;
      irq_en_q    <= irq_en_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      rem_q       <= rem_d;
      fill_val_q  <= fill_val_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign irq       = done_q && irq_en_q;

  always_comb begin
    readdata = '0;
    if (chipselect && !read_n) begin
      case (address)
        REG_ADDR: readdata = 32'(addr_ptr_q);
        REG_DATA: readdata = '0;
        REG_FILL: readdata = {rem_q, 16'(fill_val_q)};
        REG_CTRL: begin
          readdata[STAT_AUTOINC] = autoinc_q;
          readdata[STAT_OVF]     = ovf_q;
          readdata[STAT_DONE]    = done_q;
          readdata[STAT_BUSY]    = busy;
          readdata[STAT_EMPTY]   = fifo_empty;
          readdata[STAT_IRQ_EN]  = irq_en_q;
        end
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_ram_write_ctrl.sv
// Directed bench for sample_ram_write_ctrl: a register-access vector table plus
// hand-written sequences, with granted RAM writes collected into a scoreboard.
module tb_sample_ram_write_ctrl;
  import sample_ram_write_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_gnt = 1'b0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } ram_wr_t;
  ram_wr_t sb[$];

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_IDLE} op_e;
  typedef struct {
    op_e         op;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  sample_ram_write_ctrl #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_gnt    (ram_gnt),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we && ram_gnt) sb.push_back({ram_addr, ram_wdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    #1;
    d          = readdata;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic [31:0] v;
    int n;
    n = 0;
    reg_read(REG_CTRL, v);
    while (v[STAT_BUSY] && n < budget) begin
      @(negedge clk);
      reg_read(REG_CTRL, v);
      n++;
    end
    checks++;
    if (v[STAT_BUSY]) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic check_sb(input string name, input int idx, input logic [15:0] a, input logic [15:0] d);
    if (idx < sb.size()) begin
      check(name, {sb[idx].addr, sb[idx].data}, {a, d});
    end else begin
      checks++;
      failures++;
      $display("FAIL %s: write %0d missing (only %0d seen), expected %04h:%04h", name, idx, sb.size(), a, d);
    end
  endtask

  function automatic vec_t mk(input op_e op, input logic [1:0] a, input logic [31:0] wd,
                              input logic [31:0] exp, input string name);
    vec_t v;
    v.op    = op;
    v.addr  = a;
    v.wdata = wd;
    v.exp   = exp;
    v.name  = name;
    return v;
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [31:0] v;
    logic [15:0] pa, pd;
    logic        prev_we, prev_gnt;
    logic [3:0]  pat;
    int          sb_at_reset;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check("reset ram_we", 32'(ram_we), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset readdata", readdata, 32'h0);
    reset_n = 1'b1;
    ram_gnt = 1'b1;

    // ---------------- test 1: three queued writes, gnt high ----------------
    vecs.push_back(mk(OP_RD,   REG_CTRL, 32'h0,     32'h11,  "t1 reset ctrl"));
    vecs.push_back(mk(OP_RD,   REG_ADDR, 32'h0,     32'h0,   "t1 reset addr"));
    vecs.push_back(mk(OP_RD,   REG_FILL, 32'h0,     32'h0,   "t1 reset fill"));
    vecs.push_back(mk(OP_WR,   REG_ADDR, 32'h0100,  32'h0,   "t1 set addr"));
    vecs.push_back(mk(OP_RD,   REG_ADDR, 32'h0,     32'h100, "t1 addr readback"));
    vecs.push_back(mk(OP_WR,   REG_DATA, 32'hAAAA,  32'h0,   "t1 data0"));
    vecs.push_back(mk(OP_WR,   REG_DATA, 32'hBBBB,  32'h0,   "t1 data1"));
    vecs.push_back(mk(OP_WR,   REG_DATA, 32'hCCCC,  32'h0,   "t1 data2"));
    vecs.push_back(mk(OP_IDLE, REG_CTRL, 32'h0,     32'h0,   "t1 drain idle"));
    vecs.push_back(mk(OP_RD,   REG_ADDR, 32'h0,     32'h103, "t1 addr after"));
    vecs.push_back(mk(OP_RD,   REG_CTRL, 32'h0,     32'h15,  "t1 ctrl done"));
    vecs.push_back(mk(OP_RD,   REG_DATA, 32'h0,     32'h0,   "t1 data reads zero"));

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:   reg_write(vecs[i].addr, vecs[i].wdata);
        OP_RD: begin
          reg_read(vecs[i].addr, v);
          check(vecs[i].name, v, vecs[i].exp);
        end
        default: wait_idle(vecs[i].name, 50);
      endcase
    end
    check("t1 write count", sb.size(), 3);
    check_sb("t1 w0", 0, 16'h0100, 16'hAAAA);
    check_sb("t1 w1", 1, 16'h0101, 16'hBBBB);
    check_sb("t1 w2", 2, 16'h0102, 16'hCCCC);

    // ---------------- test 2: overflow at depth 8 ----------------
    reg_write(REG_CTRL, 32'h0D);
    ram_gnt = 1'b0;
    reg_write(REG_ADDR, 32'h0200);
    sb.delete();
    for (int i = 0; i < 9; i++) begin
      reg_write(REG_DATA, 32'h1000 + i);
      if (i == 0) begin
        check("t2 first we latency", 32'(ram_we), 32'h1);
        check("t2 first addr", 32'(ram_addr), 32'h0200);
        check("t2 first data", 32'(ram_wdata), 32'h1000);
      end
    end
    reg_read(REG_CTRL, v);
    check("t2 ctrl ovf busy", v, 32'h0B);
    check("t2 addr held", 32'(ram_addr), 32'h0200);
    check("t2 data held", 32'(ram_wdata), 32'h1000);
    reg_read(REG_ADDR, v);
    check("t2 addr ptr", v, 32'h0208);
    check("t2 no writes w/o gnt", sb.size(), 0);
    @(negedge clk);
    ram_gnt = 1'b1;
    wait_idle("t2 drain idle", 50);
    check("t2 write count", sb.size(), 8);
    for (int i = 0; i < 8; i++) check_sb("t2 word", i, 16'h0200 + 16'(i), 16'h1000 + 16'(i));
    reg_write(REG_CTRL, 32'h05);
    reg_read(REG_CTRL, v);
    check("t2 ovf cleared", v, 32'h15);

    // ---------------- test 3: FILL wrapping the address space ----------------
    reg_write(REG_CTRL, 32'h0D);
    ram_gnt = 1'b0;
    reg_write(REG_ADDR, 32'hFFFE);
    sb.delete();
    reg_write(REG_FILL, 32'h0004_0000);
    reg_read(REG_ADDR, v);
    check("t3 addr advanced", v, 32'h0002);
    reg_read(REG_FILL, v);
    check("t3 fill readback", v, 32'h0004_0000);
    reg_write(REG_DATA, 32'h1234);
    reg_write(REG_FILL, 32'h0002_1111);
    reg_read(REG_CTRL, v);
    check("t3 ctrl ovf busy", v, 32'h1B);
    reg_read(REG_FILL, v);
    check("t3 busy fill ignored", v, 32'h0004_0000);
    @(negedge clk);
    ram_gnt = 1'b1;
    wait_idle("t3 fill idle", 50);
    check("t3 write count", sb.size(), 4);
    check_sb("t3 w0", 0, 16'hFFFE, 16'h0000);
    check_sb("t3 w1", 1, 16'hFFFF, 16'h0000);
    check_sb("t3 w2", 2, 16'h0000, 16'h0000);
    check_sb("t3 w3", 3, 16'h0001, 16'h0000);
    reg_read(REG_CTRL, v);
    check("t3 ctrl done", v, 32'h17);
    reg_read(REG_ADDR, v);
    check("t3 addr unchanged", v, 32'h0002);

    // ---------------- test 4: grant toggling 1-0-0-1 during DRAIN ----------------
    reg_write(REG_CTRL, 32'h0D);
    ram_gnt = 1'b0;
    reg_write(REG_ADDR, 32'h0300);
    sb.delete();
    for (int i = 0; i < 4; i++) reg_write(REG_DATA, 32'h4000 + i);
    pat      = 4'b1001;
    pa       = '0;
    pd       = '0;
    prev_we  = 1'b0;
    prev_gnt = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!prev_gnt && prev_we) begin
        check("t4 addr hold", 32'(ram_addr), 32'(pa));
        check("t4 data hold", 32'(ram_wdata), 32'(pd));
      end
      pa       = ram_addr;
      pd       = ram_wdata;
      prev_we  = ram_we;
      prev_gnt = pat[c % 4];
      ram_gnt  = pat[c % 4];
    end
    ram_gnt = 1'b1;
    wait_idle("t4 drain idle", 50);
    check("t4 write count", sb.size(), 4);
    for (int i = 0; i < 4; i++) check_sb("t4 word", i, 16'h0300 + 16'(i), 16'h4000 + 16'(i));

    // ---------------- test 5: irq after single-word FILL ----------------
    reg_write(REG_CTRL, 32'h0F);
    reg_write(REG_ADDR, 32'h0500);
    sb.delete();
    reg_write(REG_FILL, 32'h0001_5A5A);
    check("t5 we during fill", 32'(ram_we), 32'h1);
    check("t5 irq before grant", 32'(irq), 32'h0);
    @(negedge clk);
    check("t5 irq after grant", 32'(irq), 32'h1);
    check("t5 we dropped", 32'(ram_we), 32'h0);
    reg_write(REG_CTRL, 32'h0B);
    check("t5 irq cleared", 32'(irq), 32'h0);
    check("t5 write count", sb.size(), 1);
    check_sb("t5 w0", 0, 16'h0500, 16'h5A5A);

    // ---------------- test 6: reset during a long FILL ----------------
    reg_write(REG_ADDR, 32'h0600);
    sb.delete();
    reg_write(REG_FILL, {16'd100, 16'h7777});
    repeat (5) @(negedge clk);
    check("t6 writes before reset", sb.size(), 5);
    check_sb("t6 w0", 0, 16'h0600, 16'h7777);
    check_sb("t6 w4", 4, 16'h0604, 16'h7777);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 we async drop", 32'(ram_we), 32'h0);
    sb_at_reset = sb.size();
    @(negedge clk);
    reset_n = 1'b1;
    reg_read(REG_ADDR, v);
    check("t6 addr reset", v, 32'h0);
    reg_read(REG_CTRL, v);
    check("t6 ctrl reset", v, 32'h11);
    reg_read(REG_FILL, v);
    check("t6 fill reset", v, 32'h0);
    repeat (20) @(negedge clk);
    check("t6 no writes after reset", sb.size(), sb_at_reset);
    check("t6 we stays low", 32'(ram_we), 32'h0);
    check("t6 irq low", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
